// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory bus between the CPU pipeline (master) and dmem_responder (slave).
interface dmem_responder_if;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output MemRead_i, MemWrite_i, addr_i, data_i,
    input  data_o, stall_o, done_o, err_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, addr_i, data_i,
    output data_o, stall_o, done_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory that stalls the pipeline for a fixed latency per access.
// Optional error checking (misaligned / out-of-range / read+write) enabled by DMEM_RESP_ERR_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dmem_responder_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          bad_q, bad_d;
  logic          req_err_q, req_err_d;
  logic [31:0]   data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          mem_we;
  logic          stall_c;
  logic          req;
  logic          addr_bad;
  logic          both_req;

  assign req = bus.MemRead_i | bus.MemWrite_i;

`ifdef DMEM_RESP_ERR_EN
  assign addr_bad = (bus.addr_i[1:0] != 2'b00) || (bus.addr_i[31:AW+2] != '0);
  assign both_req = bus.MemRead_i & bus.MemWrite_i;
`else
  // Byte offset and upper bits are don't-care: the address wraps modulo DEPTH_WORDS.
  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0]};
  assign addr_bad    = 1'b0;
  assign both_req    = 1'b0;
`endif

  // Next-state, latched request and completion outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    bad_d     = bad_q;
    req_err_d = req_err_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = err_q;
    mem_we    = 1'b0;
    stall_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          stall_c   = 1'b1;
          idx_d     = bus.addr_i[AW+1:2];
          wdata_d   = bus.data_i;
          we_d      = bus.MemWrite_i;
          bad_d     = addr_bad;
          req_err_d = addr_bad | both_req;
          cnt_d     = CNT_LOAD;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (req_err_q) err_d = 1'b1;
          if (we_q) mem_we = ~bad_q;
          else      data_d = bad_q ? 32'h0 : mem_q[idx_q];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      bad_q     <= 1'b0;
      req_err_q <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      bad_q     <= bad_d;
      req_err_q <= req_err_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Storage is not reset; a reset on the completion edge drops the write.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) mem_q[idx_q] <= wdata_q;
  end

  assign bus.stall_o = stall_c;
  assign bus.data_o  = data_q;
  assign bus.done_o  = done_q;
  assign bus.err_o   = err_q;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the CPU's MEM stage across its existing `MemRead`/`MemWrite`/`addr`/`data` interface. It accepts one access at a time and holds off the pipeline with `stall_o` until the access completes. It replaces the zero-latency data memory, so the pipeline can be exercised against realistic memory latency. Word-addressed storage of configurable depth, with a fixed, parameterised access latency.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two, ≥ 4. `AW = log2(DEPTH_WORDS)`.
- `LATENCY`, default 3: wait cycles per access; legal range 1..15.
- `clk_i`  in  1: clock. Everything is on the rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `MemRead_i`  in  1: read request from EXMEM.
- `MemWrite_i`  in  1: write request from EXMEM.
- `addr_i`  in  32: byte address (EXMEM ALU result).
- `data_i`  in  32: write data (EXMEM store data).
- `data_o`  out  32: read data, registered.
- `stall_o`  out  1: freeze PC/IFID/IDEX/EXMEM; combinational from state and request.
- `done_o`  out  1: one-cycle pulse when an access completes, registered.
- `err_o`  out  1: sticky error flag, registered.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- Reset values: `data_o`=0, `done_o`=0, `err_o`=0, `stall_o`=0 (IDLE with no request). The counter resets to 0. The storage array is not reset.
- **IDLE:**
  - Request = `MemRead_i | MemWrite_i`.
  - On a request: latch the address, write data and op into internal registers, load `cnt = LATENCY-1`, and go to WAIT.
  - If both read and write are high, the write wins.
- **WAIT:**
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`, perform the access using the latched values and go to DONE.
  - Write: `mem[idx] <= wdata`.
  - Read: `data_o <= mem[idx]`.
  - `idx = latched_addr[AW+1:2]`.
  - Input changes during WAIT are ignored.
- **DONE:**
  - `done_o` = 1 for this cycle only.
  - `stall_o` = 0, so the pipeline advances at this edge.
  - Unconditionally go to IDLE; a request seen in DONE is not accepted.
  - The next request is sampled in IDLE on the following cycle.
- `stall_o = (IDLE & request) | WAIT`.
- `data_o` holds its value until the next read completes. Writes never change `data_o`.
- Reset mid-operation (in WAIT): return to IDLE. The pending write is discarded and the array is unchanged, because the write happens only on the WAIT→DONE edge. `data_o` is cleared.

## Timing
- Request first visible in IDLE at cycle 0.
- WAIT occupies cycles 1..LATENCY.
- DONE at cycle LATENCY+1: `data_o`/`done_o` are valid and `stall_o` is low.
- `stall_o` is high for exactly LATENCY+1 cycles (0..LATENCY) per access.
- Back-to-back accesses: the next request is accepted no earlier than cycle LATENCY+2, so the minimum period is LATENCY+2 cycles.
- A read-after-write to the same address returns the new data; accesses are serialised.

## Configuration
- Macro: `DMEM_RESP_ERR_EN`.
- **Defined:** the request latched in IDLE sets `err_o` (sticky until `rst_i`) in any of these cases:
  - `addr_i[1:0] != 0` (misaligned);
  - `addr_i[31:AW+2] != 0` (out of range);
  - both `MemRead_i` and `MemWrite_i` are high.
  
  For a misaligned or out-of-range access:
  - the write is suppressed;
  - a read returns 0.
  
  Timing is unchanged.
- **Undefined:**
  - `err_o` is tied to 0.
  - `addr_i[1:0]` is ignored.
  - Upper address bits are ignored, so the address wraps modulo `DEPTH_WORDS`.
  - Both-high requests are performed as a write.

## Test plan
- **Write then read, default params:** write 0xDEADBEEF to 0x10, then read 0x10. Each access has `stall_o` high 4 cycles and `done_o` on cycle 4. The read then shows `data_o`=0xDEADBEEF, held until the next read.
- **Back-to-back reads with LATENCY=1:** reads of 0x0 and 0x4 (preloaded 1 and 2). `done_o` pulses 3 cycles apart, and `data_o` goes 1 then 2.
- **Reset mid-write:** assert `rst_i` in the second WAIT cycle of a write of 0x55 to 0x8 (previously 0x11). Next cycle: IDLE, `stall_o`=0, `data_o`=0. A subsequent read of 0x8 returns 0x11.
- **Error, macro defined:** a read of 0x6 gives `err_o`=1 from the DONE cycle onward and `data_o`=0. A write of 0x400 (DEPTH 256) leaves mem[0] unchanged. `err_o` stays 1 until reset.
- **Wrap, macro undefined:** a write of 0xA5 to 0x400 then a read of 0x0 returns 0xA5, and `err_o` stays 0.
- **Request in DONE:** hold `MemRead_i` continuously. A second access starts only after returning to IDLE: `done_o` pulses every LATENCY+2 cycles.
